// File: rtl/sum_accum.sv
// Frame accumulator: sums CNT unsigned adder results into an ACC_W-bit total, one output beat per frame.
// Define SUM_ACCUM_SAT_EN to saturate the frame total instead of wrapping.
module sum_accum #(
    parameter int N     = 32,
    parameter int CNT   = 4,
    parameter int ACC_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = $clog2(CNT) + 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, acc_step;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ovf, ovf_nxt, ovf_step;
    logic [ACC_W:0]   sum;
    logic             accept, last, load;

    // One extra bit on the sum catches the carry out of the accumulator.
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W-N){1'b0}}, in_data};
        ovf_step = ovf | sum[ACC_W];
`ifdef SUM_ACCUM_SAT_EN
        acc_step = (sum[ACC_W] || (ovf && (&acc))) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_step = sum[ACC_W-1:0];
`endif
    end

    // clear blocks acceptance so its in_data can never leak into a fresh frame.
    assign in_ready  = (state == ACCUM) && !clear;
    assign out_valid = (state == HOLD);
    assign busy      = (cnt != '0) || (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(CNT-1));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        load      = 1'b0;
        if (clear) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            load      = 1'b1;
                            state_nxt = HOLD;
                            acc_nxt   = '0;
                            cnt_nxt   = '0;
                            ovf_nxt   = 1'b0;
                        end else begin
                            acc_nxt = acc_step;
                            cnt_nxt = cnt + CW'(1);
                            ovf_nxt = ovf_step;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state_nxt = ACCUM;
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            if (load) begin
                out_data <= acc_step;
                out_ovf  <= ovf_step;
            end
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: default build, a narrow ACC_W=34 instance and a CNT=1 instance.
module tb_sum_accum;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance (N=32, CNT=4, ACC_W=36)
    logic        a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_out_ovf, a_busy;
    logic [32:0] a_in_data;
    logic [35:0] a_out_data;
    // ACC_W=34 instance
    logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_out_ovf, b_busy;
    logic [32:0] b_in_data;
    logic [33:0] b_out_data;
    // CNT=1 instance
    logic        c_in_valid, c_in_ready, c_clear, c_out_valid, c_out_ready, c_out_ovf, c_busy;
    logic [32:0] c_in_data;
    logic [35:0] c_out_data;

    sum_accum #(.N(32), .CNT(4), .ACC_W(36)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .clear(a_clear), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf), .busy(a_busy));

    sum_accum #(.N(32), .CNT(4), .ACC_W(34)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .clear(b_clear), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .busy(b_busy));

    sum_accum #(.N(32), .CNT(1), .ACC_W(36)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .clear(c_clear), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_ovf(c_out_ovf), .busy(c_busy));

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [32:0] cvals [4];
    logic [33:0] b_exp;
    logic [35:0] held;

    initial begin
        cvals[0] = 33'h0_0000_0011;
        cvals[1] = 33'h1_2345_6789;
        cvals[2] = 33'h1_FFFF_FFFF;
        cvals[3] = 33'h0_0000_0000;
`ifdef SUM_ACCUM_SAT_EN
        b_exp = 34'h3_FFFF_FFFF;
`else
        b_exp = 34'h3_FFFF_FFFC;
`endif
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_clear = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_clear = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_clear = 0; c_out_ready = 0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_ovf", a_out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1,2,3,4 back to back, consumer always ready
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 33'(i + 1);
            chk("t1_in_ready", a_in_ready, 1);
            @(negedge clk);
        end
        a_in_valid = 0;
        chk("t1_out_valid", a_out_valid, 1);
        chk("t1_out_data", a_out_data, 10);
        chk("t1_out_ovf", a_out_ovf, 0);
        chk("t1_in_ready_low", a_in_ready, 0);
        @(negedge clk);
        chk("t1_in_ready_back", a_in_ready, 1);
        chk("t1_out_valid_drop", a_out_valid, 0);

        // max words, consumer stalls 5 cycles
        a_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 33'h1_FFFF_FFFF;
            @(negedge clk);
        end
        a_in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_out_valid", a_out_valid, 1);
            chk("t2_in_ready", a_in_ready, 0);
            chk("t2_out_data", a_out_data, 36'h7_FFFF_FFFC);
            chk("t2_out_ovf", a_out_ovf, 0);
            @(negedge clk);
        end
        a_out_ready = 1;
        @(negedge clk);
        chk("t2_out_valid_drop", a_out_valid, 0);

        // narrow accumulator overflow, then a clean frame
        b_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_in_data = 33'h1_FFFF_FFFF;
            @(negedge clk);
        end
        b_in_valid = 0;
        chk("t3_out_valid", b_out_valid, 1);
        chk("t3_out_data", b_out_data, b_exp);
        chk("t3_out_ovf", b_out_ovf, 1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_in_data = 33'd1;
            @(negedge clk);
        end
        b_in_valid = 0;
        chk("t3b_out_valid", b_out_valid, 1);
        chk("t3b_out_data", b_out_data, 4);
        chk("t3b_out_ovf", b_out_ovf, 0);
        @(negedge clk);

        // clear mid-frame discards partial sum
        a_in_valid = 1; a_in_data = 33'd5;
        @(negedge clk);
        chk("t4_busy_partial", a_busy, 1);
        a_in_data = 33'd6;
        @(negedge clk);
        held = a_out_data;
        a_in_data = 33'd100; a_clear = 1;
        #1;
        chk("t4_in_ready_clear", a_in_ready, 0);
        @(negedge clk);
        a_clear = 0; a_in_valid = 0;
        chk("t4_busy_cleared", a_busy, 0);
        chk("t4_no_output", a_out_valid, 0);
        chk("t4_out_data_kept", a_out_data, 36'h7_FFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 33'd1;
            @(negedge clk);
        end
        a_in_valid = 0;
        chk("t4_out_valid", a_out_valid, 1);
        chk("t4_out_data", a_out_data, 4);
        @(negedge clk);
        chk("t4_single_output", a_out_valid, 0);

        // asynchronous reset while holding an output
        a_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 33'd9;
            @(negedge clk);
        end
        a_in_valid = 0;
        chk("t5_hold_valid", a_out_valid, 1);
        chk("t5_hold_data", a_out_data, 36);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_out_valid", a_out_valid, 0);
        chk("t5_async_busy", a_busy, 0);
        chk("t5_async_in_ready", a_in_ready, 1);
        chk("t5_async_out_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1; a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 33'd7;
            @(negedge clk);
        end
        a_in_valid = 0;
        chk("t5_out_valid", a_out_valid, 1);
        chk("t5_out_data", a_out_data, 28);
        chk("t5_out_ovf", a_out_ovf, 0);
        @(negedge clk);

        // CNT=1: each accepted word becomes its own frame, one every 2 cycles
        c_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            c_in_valid = 1; c_in_data = cvals[i];
            chk("t6_in_ready", c_in_ready, 1);
            @(negedge clk);
            chk("t6_out_valid", c_out_valid, 1);
            chk("t6_out_data", c_out_data, {3'b000, cvals[i]});
            chk("t6_in_ready_low", c_in_ready, 0);
            @(negedge clk);
            chk("t6_out_valid_drop", c_out_valid, 0);
        end
        c_in_valid = 0;
        chk("t6_busy_idle", c_busy, 0);
        chk("t6_out_ovf", c_out_ovf, 0);
        chk("t3_busy_idle", b_busy, 0);
        chk("t3_in_ready_idle", b_in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
